// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Time-multiplexed 7-segment display driver for the HH:MM:SS BCD counter chain.
// Scans a frame snapshot of the packed BCD digits onto a multiplexed display,
// inserting a one-cycle anode blanking slot at every digit change, with
// per-digit blink, leading-zero suppression and decimal-point control.
module seg7_scan_driver #(
    parameter int NUM_DIGITS     = 6,
    parameter int SCAN_DIV       = 50000,
    parameter int BLINK_DIV      = 250,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic                    blank_lz,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    scan_tick
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PS_W  = $clog2(SCAN_DIV);
    localparam int BL_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(SCAN_DIV - 1);
    localparam logic [BL_W-1:0]  BL_LAST  = BL_W'(BLINK_DIV - 1);

    // XOR masks that turn active-high internal values into pin levels.
    localparam logic [6:0]            SEG_INV = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic                  DP_INV  = SEG_ACTIVE_LOW;
    localparam logic [NUM_DIGITS-1:0] AN_INV  = AN_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    logic [PS_W-1:0]         prescaler;
    logic [IDX_W-1:0]        idx;
    logic [BL_W-1:0]         blink_cnt;
    logic                    blink_phase;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic                    load_pending;

    logic                    tick;
    logic [4*NUM_DIGITS-1:0] view;
    logic                    zero_run;
    logic [3:0]              cur_digit;
    logic                    cur_blink;
    logic                    cur_dp;
    logic                    cur_lz;
    logic [NUM_DIGITS-1:0]   onehot;

    logic [NUM_DIGITS-1:0]   an_nxt;
    logic [6:0]              seg_nxt;
    logic                    dp_nxt;

    // BCD to active-high gfedcba; non-BCD codes show a lone dash.
    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'h3F;
            4'd1:    p = 7'h06;
            4'd2:    p = 7'h5B;
            4'd3:    p = 7'h4F;
            4'd4:    p = 7'h66;
            4'd5:    p = 7'h6D;
            4'd6:    p = 7'h7D;
            4'd7:    p = 7'h07;
            4'd8:    p = 7'h7F;
            4'd9:    p = 7'h6F;
            default: p = 7'h40;
        endcase
        return p;
    endfunction

    assign tick = (prescaler == PS_LAST);

    // Slot timing: prescaler, digit index and blink phase all advance on ticks.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            prescaler   <= '0;
            idx         <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (tick) begin
            prescaler <= '0;
            idx       <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            if (blink_cnt == BL_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    // Frame snapshot: captured at the frame wrap and once right after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow       <= '0;
            load_pending <= 1'b1;
        end else begin
            if (load_pending || (tick && idx == IDX_LAST)) begin
                shadow <= digits;
            end
            load_pending <= 1'b0;
        end
    end

    // While the first snapshot is loading, show what is being captured so the
    // first slot after reset already carries the fresh value.
    assign view = load_pending ? digits : shadow;

    // Select the current digit, its masks and its leading-zero status.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        cur_digit = '0;
        cur_blink = 1'b0;
        cur_dp    = 1'b0;
        cur_lz    = 1'b0;
        onehot    = '0;
        zero_run  = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run = zero_run & (view[4*k +: 4] == 4'd0);
            if (idx == IDX_W'(k)) begin
                cur_digit = view[4*k +: 4];
                cur_blink = blink_mask[k];
                cur_dp    = dp_mask[k];
                cur_lz    = zero_run && (k != 0);
                onehot[k] = 1'b1;
            end
        end
    end

    // Next pin values: dark during the blanking slot, blink-off or leading zero.
    always_comb begin
        an_nxt  = '0;
        seg_nxt = '0;
        dp_nxt  = 1'b0;
        if (!tick && !(cur_blink && blink_phase) && !(blank_lz && cur_lz)) begin
            an_nxt  = onehot;
            seg_nxt = decode(cur_digit);
            dp_nxt  = cur_dp;
        end
    end

    // Registered pin drivers with polarity applied last.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an        <= AN_INV;
            seg       <= SEG_INV;
            dp        <= DP_INV;
            scan_tick <= 1'b0;
        end else begin
            an        <= an_nxt ^ AN_INV;
            seg       <= seg_nxt ^ SEG_INV;
            dp        <= dp_nxt ^ DP_INV;
            scan_tick <= tick;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver
// Self-checking bench: each cycle's expected pins come from slot arithmetic on
// the cycle count since reset release plus a queue of per-frame snapshots.
module tb_seg7_scan_driver;

    localparam int N = 6;
    localparam int S = 4;
    localparam int B = 2;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [23:0]  digits = '0;
    logic [5:0]   blink_mask = '0;
    logic [5:0]   dp_mask = '0;
    logic         blank_lz = 1'b0;
    logic [6:0]   seg;
    logic         dp;
    logic [5:0]   an;
    logic         scan_tick;

    int tests  = 0;
    int failed = 0;
    int c      = 0;

    logic [23:0] snaps[$];
    logic [5:0]  prev_bm  = '0;
    logic [5:0]  prev_dm  = '0;
    logic        prev_blz = 1'b0;

    logic [6:0] seg_lut [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

    seg7_scan_driver #(
        .NUM_DIGITS(N), .SCAN_DIV(S), .BLINK_DIV(B),
        .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)
    ) dut (
        .clk(clk), .reset(reset), .digits(digits), .blink_mask(blink_mask),
        .dp_mask(dp_mask), .blank_lz(blank_lz), .seg(seg), .dp(dp), .an(an),
        .scan_tick(scan_tick)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s c=%0d observed=%0h expected=%0h", tag, c, obs, exp);
        end
    endtask

    // Check the current cycle (sampled at negedge), then drive the inputs for it.
    task automatic cycle_step(input logic [23:0] d, input logic [5:0] bm,
                              input logic [5:0] dm, input logic blz);
        int n, k;
        logic [23:0] sv;
        logic [3:0]  dig;
        logic [31:0] exp_an;
        logic        lit;
        logic        exp_tick;
        exp_tick = (c > 0) && (c % S == 0);
        check("scan_tick", 32'(scan_tick), 32'(exp_tick));
        if (c == 0 || exp_tick) begin
            check("an_blank_slot", 32'(an), 32'd0);
        end else begin
            n   = c / S;
            k   = n % N;
            sv  = snaps[n / N];
            dig = sv[4*k +: 4];
            lit = !(prev_bm[k] && ((n / B) % 2 == 1)) &&
                  !(prev_blz && k > 0 && (sv >> (4*k)) == 24'd0);
            exp_an = lit ? (32'd1 << k) : 32'd0;
            check("an", 32'(an), exp_an);
            if (lit) begin
                check("seg", 32'(seg), 32'(seg_lut[dig]));
                check("dp", 32'(dp), 32'(prev_dm[k]));
            end
        end
        digits     = d;
        blink_mask = bm;
        dp_mask    = dm;
        blank_lz   = blz;
        if (c == 0 || (c + 1) % (N * S) == 0) snaps.push_back(d);
        prev_bm  = bm;
        prev_dm  = dm;
        prev_blz = blz;
        @(posedge clk);
        c++;
        @(negedge clk);
    endtask

    // Asynchronous reset mid-cycle: pins must go inactive with no clock edge.
    task automatic async_reset(input logic [23:0] d);
        #1 reset = 1'b1;
        #1;
        check("rst_an", 32'(an), 32'd0);
        check("rst_seg", 32'(seg), 32'd0);
        check("rst_dp", 32'(dp), 32'd0);
        check("rst_scan_tick", 32'(scan_tick), 32'd0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        digits = d;
        reset  = 1'b0;
        c      = 0;
        snaps.delete();
    endtask

    initial begin
        logic [23:0] r_d;
        logic [5:0]  r_bm, r_dm;
        logic        r_blz;

        // Power-up reset with 123456 on the inputs.
        digits = 24'h123456;
        @(negedge clk);
        async_reset(24'h123456);

        // One full frame of 123456.
        repeat (N * S) cycle_step(24'h123456, 6'b0, 6'b0, 1'b0);

        // Change digits mid-frame while idx=2; the frame in flight must not tear.
        for (int i = 0; i < N * S && !(((c / S) % N) == 2 && (c % S) == 2); i++)
            cycle_step(24'h123456, 6'b0, 6'b0, 1'b0);
        for (int i = 0; i < N * S && (c % (N * S)) != 0; i++)
            cycle_step(24'h000000, 6'b0, 6'b0, 1'b0);
        repeat (N * S) cycle_step(24'h000000, 6'b0, 6'b0, 1'b0);

        // Leading-zero suppression on and then off.
        repeat (2 * N * S) cycle_step(24'h000507, 6'b0, 6'b0, 1'b1);
        repeat (2 * N * S) cycle_step(24'h000507, 6'b0, 6'b0, 1'b0);

        // Blinking of the two rightmost digits.
        repeat (2 * N * S) cycle_step(24'h123456, 6'b000011, 6'b0, 1'b0);

        // Non-BCD code and a single decimal point, with leading-zero suppression.
        repeat (2 * N * S) cycle_step(24'h12345B, 6'b0, 6'b000100, 1'b1);
        // dp on a leading zero that gets blanked anyway.
        repeat (2 * N * S) cycle_step(24'h000001, 6'b0, 6'b100000, 1'b1);

        // Reset in the middle of slot 4, then a fresh frame.
        for (int i = 0; i < 2 * N * S && !(((c / S) % N) == 4 && (c % S) == 2); i++)
            cycle_step(24'h123456, 6'b0, 6'b0, 1'b0);
        async_reset(24'h987654);
        repeat (N * S) cycle_step(24'h987654, 6'b0, 6'b0, 1'b0);

        // Random traffic against the slot model.
        r_d   = 24'h102030;
        r_bm  = 6'b0;
        r_dm  = 6'b0;
        r_blz = 1'b1;
        repeat (10 * N * S) begin
            if ($urandom_range(0, 7) == 0) begin
                for (int i = 0; i < N; i++)
                    r_d[4*i +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 15) == 0) r_bm  = 6'($urandom);
            if ($urandom_range(0, 15) == 0) r_dm  = 6'($urandom);
            if ($urandom_range(0, 31) == 0) r_blz = 1'($urandom);
            cycle_step(r_d, r_bm, r_dm, r_blz);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Time-multiplexed 7-segment display driver. It is the reader side of the BCD digit counter chain.
- Takes the packed BCD digits produced by the cascaded modular counters (HH:MM:SS) and scans them onto a common-anode/cathode multiplexed display.
- Adds tear-free frame snapshotting, per-digit blinking for time-set mode, leading-zero blanking and decimal-point control.
- Sits between the clock counter chain and the FPGA display pins.

Parameters:
- NUM_DIGITS, 6, number of display digits (legal 1..8).
- SCAN_DIV, 50000, clk cycles per digit slot (legal >= 2).
- BLINK_DIV, 250, scan ticks per blink half-period (legal >= 1).
- SEG_ACTIVE_LOW, 1, 1 = seg/dp outputs inverted at the pins.
- AN_ACTIVE_LOW, 1, 1 = an outputs inverted at the pins.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- digits  in  4*NUM_DIGITS  packed BCD; digit i = digits[4i+3:4i]; digit 0 = rightmost (seconds units).
- blink_mask  in  NUM_DIGITS  1 = digit blinks.
- dp_mask  in  NUM_DIGITS  1 = decimal point lit on that digit.
- blank_lz  in  1  1 = suppress leading zeros.
- seg  out  7  segments, seg[0]=a .. seg[6]=g.
- dp  out  1  decimal point.
- an  out  NUM_DIGITS  digit enables, one-hot when active.
- scan_tick  out  1  one-cycle pulse per digit slot change.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high. All registers clear immediately on reset assertion.
- Reset values: prescaler=0, idx=0, blink_phase=0, shadow=0, load_pending=1, an all inactive, seg all off, dp off, scan_tick=0. All values are given after polarity is applied.
- Prescaler: counts 0..SCAN_DIV-1 and wraps to 0. The internal tick is high in the cycle where prescaler==SCAN_DIV-1.
- Digit index:
  - On the edge ending a tick cycle, idx <= (idx==NUM_DIGITS-1) ? 0 : idx+1.
  - idx never leaves the range 0..NUM_DIGITS-1.
- Snapshot:
  - shadow <= digits on the edge where idx wraps NUM_DIGITS-1 -> 0.
  - shadow also loads on the first clk edge after reset deassertion (load_pending=1), then load_pending clears.
  - All decoding and leading-zero evaluation use shadow only. A mid-frame change on digits never tears a frame.
  - blink_mask and dp_mask are used live, not snapshotted.
- Blanking slot (anti-ghosting):
  - In the cycle immediately after idx changes, an is all inactive.
  - scan_tick=1 in that same cycle and 0 in every other cycle.
  - From the next cycle until the next idx change, an drives one-hot bit idx.
- Registered outputs: an, seg and dp are registered and update one clk after the selected shadow digit or mask value changes.
- Decode: active-high gfedcba patterns.
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Codes 10..15 display 40 (dash only).
  - Polarity inversion is applied last.
- Blink:
  - A blink counter counts scan ticks 0..BLINK_DIV-1.
  - blink_phase toggles on its wrap.
  - When blink_phase=1 and blink_mask[idx]=1, an for that slot stays inactive. seg and dp are don't-care in that case.
- Leading zeros:
  - Applies only when blank_lz=1.
  - Digit k>0 is blanked (an inactive) if shadow digits NUM_DIGITS-1 down to k are all 0.
  - Digit 0 is never leading-zero blanked.
  - A lit dp_mask bit does not prevent blanking.
- dp: equals dp_mask[idx] during active slots.
- Simultaneous events: a blank from blink or leading-zero suppression overrides dp and the decode.
- Reset mid-frame: outputs go inactive immediately. The scan restarts at digit 0 with a fresh snapshot.

Test Plan:
All scenarios use SCAN_DIV=4, NUM_DIGITS=6, BLINK_DIV=2, SEG_ACTIVE_LOW=0, AN_ACTIVE_LOW=0.
1. Reset with digits=24'h123456, release, run 1 frame -> an steps 000001..100000. Each slot is 1 blank cycle (an=0, scan_tick=1) + 3 active cycles. seg per slot: 7D, 6D, 66, 4F, 5B, 06.
2. Change digits to 24'h000000 while idx=2 -> slots 3..5 still show 4F, 5B, 06. The new value 3F appears from the next digit-0 slot.
3. digits=24'h000507, blank_lz=1 -> slots 3..5 show an=0. Slots 0..2 show 07, 3F, 6D. With blank_lz=0, slots 3..5 show 3F.
4. blink_mask=6'b000011 -> slots 0,1 are lit in frames where blink_phase=0 and dark in frames where blink_phase=1 (toggling every 2 ticks). Other slots are always lit.
5. digits nibble 0 = 4'hB, dp_mask=6'b000100 -> slot 0 seg=40. dp=1 only in slot 2.
6. Assert reset mid-slot at idx=4 -> an=0, seg=0, dp=0 in the same cycle with no clock edge. After release, the first active slot is digit 0 and shows the freshly loaded value.
